// File: rtl/hpf_y_sink_packer.sv
// hpf_y_sink_packer: accepts 32-bit filter samples on the Y data/valid/ack handshake,
// buffers them in a small FIFO and serializes each one as a 5-byte frame (sync byte + 4 bytes MSB first).
// Latency: capture edge E, sync byte valid from E+1, frame complete on E+6 with ready held high.
// Backpressure: a full FIFO withholds the ack unless HPF_SINK_DROP_ON_FULL_EN is defined (then: ack, drop, set o_OVERFLOW).
module hpf_y_sink_packer #(
  parameter int         FIFO_DEPTH = 4,
  parameter int         ADDR_W     = 2,
  parameter logic [7:0] SYNC_BYTE  = 8'hA5
) (
  input  logic              i_CLK,
  input  logic              w_rstn,
  input  logic [31:0]       i_Y_DATA,
  input  logic              i_Y_DATA_VALID,
  output logic              o_Y_ACK,
  output logic [7:0]        o_BYTE,
  output logic              o_BYTE_VALID,
  input  logic              i_BYTE_READY,
  output logic [ADDR_W:0]   o_FIFO_COUNT,
  output logic              o_OVERFLOW,
  input  logic              i_CLR_OVF
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SYNC = 2'd1,
    ST_DATA = 2'd2
  } st_t;

  localparam logic [ADDR_W:0]   DEPTH_C = (ADDR_W+1)'(FIFO_DEPTH);
  localparam logic [ADDR_W:0]   CNT_ONE = (ADDR_W+1)'(1);
  localparam logic [ADDR_W-1:0] PTR_ONE = (ADDR_W)'(1);

  st_t               state;
  logic [31:0]       mem [FIFO_DEPTH];
  logic [ADDR_W-1:0] wr_ptr;
  logic [ADDR_W-1:0] rd_ptr;
  logic [31:0]       word;
  logic [1:0]        idx;
  logic [ADDR_W:0]   cnt_nxt;

  logic full;
  logic empty;
  logic offer;
  logic wr_en;
  logic ack_set;
  logic xfer;
  logic pop;

  assign full  = (o_FIFO_COUNT == DEPTH_C);
  assign empty = (o_FIFO_COUNT == '0);
  // The ack cycle itself never captures, so a held valid is taken only once.
  assign offer = i_Y_DATA_VALID && !o_Y_ACK;
  assign wr_en = offer && !full;
  assign xfer  = o_BYTE_VALID && i_BYTE_READY;
  // The serializer pops when idle, or when the last byte of a frame leaves so frames run back to back.
  assign pop   = !empty && ((state == ST_IDLE) ||
                            ((state == ST_DATA) && xfer && (idx == 2'd3)));

`ifdef HPF_SINK_DROP_ON_FULL_EN
  // Every offered sample is acked; samples arriving while full are discarded.
  assign ack_set = offer;

  // Sticky drop flag; a drop on the same edge as a clear keeps the flag set.
  always_ff @(posedge i_CLK or negedge w_rstn) begin
    if (!w_rstn) begin
      o_OVERFLOW <= 1'b0;
    end else if (offer && full) begin
      o_OVERFLOW <= 1'b1;
    end else if (i_CLR_OVF) begin
      o_OVERFLOW <= 1'b0;
    end
  end
`else
  logic unused_clr_ovf;

  // Only stored samples are acked; a full FIFO stalls the producer.
  assign ack_set        = wr_en;
  assign o_OVERFLOW     = 1'b0;
  assign unused_clr_ovf = i_CLR_OVF;
`endif

  // Single-cycle acknowledge for each accepted (or dropped) sample.
  always_ff @(posedge i_CLK or negedge w_rstn) begin
    if (!w_rstn) begin
      o_Y_ACK <= 1'b0;
    end else begin
      o_Y_ACK <= ack_set;
    end
  end

  // Next occupancy: a write and a pop on the same edge cancel out.
  always_comb begin
    cnt_nxt = o_FIFO_COUNT;
    if (wr_en && !pop) begin
      cnt_nxt = o_FIFO_COUNT + CNT_ONE;
    end else if (!wr_en && pop) begin
      cnt_nxt = o_FIFO_COUNT - CNT_ONE;
    end
  end

  // FIFO storage; no reset needed since occupancy gates every read.
  always_ff @(posedge i_CLK) begin
    if (wr_en) begin
      mem[wr_ptr] <= i_Y_DATA;
    end
  end

  // FIFO pointers and registered occupancy count.
  always_ff @(posedge i_CLK or negedge w_rstn) begin
    if (!w_rstn) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      o_FIFO_COUNT <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop)   rd_ptr <= rd_ptr + PTR_ONE;
      o_FIFO_COUNT <= cnt_nxt;
    end
  end

  // Frame serializer: sync byte, then the word shifted out MSB first, one byte per transfer.
  always_ff @(posedge i_CLK or negedge w_rstn) begin
    if (!w_rstn) begin
      state        <= ST_IDLE;
      word         <= '0;
      idx          <= '0;
      o_BYTE       <= '0;
      o_BYTE_VALID <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          o_BYTE_VALID <= 1'b0;
          if (pop) begin
            word         <= mem[rd_ptr];
            o_BYTE       <= SYNC_BYTE;
            o_BYTE_VALID <= 1'b1;
            state        <= ST_SYNC;
          end
        end
        ST_SYNC: begin
          if (xfer) begin
            o_BYTE <= word[31:24];
            word   <= {word[23:0], 8'h00};
            idx    <= 2'd0;
            state  <= ST_DATA;
          end
        end
        ST_DATA: begin
          if (xfer) begin
            if (idx == 2'd3) begin
              if (pop) begin
                word   <= mem[rd_ptr];
                o_BYTE <= SYNC_BYTE;
                state  <= ST_SYNC;
              end else begin
                o_BYTE_VALID <= 1'b0;
                state        <= ST_IDLE;
              end
            end else begin
              idx    <= idx + 2'd1;
              o_BYTE <= word[31:24];
              word   <= {word[23:0], 8'h00};
            end
          end
        end
        default: begin
          o_BYTE_VALID <= 1'b0;
          state        <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_hpf_y_sink_packer.sv
// Testbench for hpf_y_sink_packer: directed scenarios plus a randomized run,
// checked against a frame-level model (each accepted sample -> A5 + 4 bytes MSB first).
`timescale 1ns/1ps
module tb_hpf_y_sink_packer;

  localparam int         DEPTH = 4;
  localparam logic [7:0] SYNC  = 8'hA5;
`ifdef HPF_SINK_DROP_ON_FULL_EN
  localparam bit DROP_MODE = 1'b1;
`else
  localparam bit DROP_MODE = 1'b0;
`endif

  logic        clk;
  logic        rstn;
  logic [31:0] y_data;
  logic        y_vld;
  logic        y_ack;
  logic [7:0]  byte_dat;
  logic        byte_vld;
  logic        byte_rdy;
  logic [2:0]  fifo_cnt;
  logic        ovf;
  logic        clr_ovf;

  int n_checks;
  int n_fail;
  int cyc;
  int ack_cnt;

  logic [7:0]  got_q[$];
  int          got_t[$];
  logic [7:0]  exp_q[$];

  logic        pv;
  logic        pr;
  logic [7:0]  pb;
  bit          prod_done;
  logic [31:0] rd;

  hpf_y_sink_packer #(.FIFO_DEPTH(4), .ADDR_W(2), .SYNC_BYTE(8'hA5)) dut (
    .i_CLK          (clk),
    .w_rstn         (rstn),
    .i_Y_DATA       (y_data),
    .i_Y_DATA_VALID (y_vld),
    .o_Y_ACK        (y_ack),
    .o_BYTE         (byte_dat),
    .o_BYTE_VALID   (byte_vld),
    .i_BYTE_READY   (byte_rdy),
    .o_FIFO_COUNT   (fifo_cnt),
    .o_OVERFLOW     (ovf),
    .i_CLR_OVF      (clr_ovf)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  // Byte/ack monitor sampled mid-cycle; also checks that a stalled byte is held.
  always @(negedge clk) begin
    if (!rstn) begin
      pv = 1'b0;
    end else begin
      if (pv && !pr) begin
        n_checks++;
        if (byte_vld !== 1'b1 || byte_dat !== pb) begin
          n_fail++;
          $display("FAIL hold: byte %h valid %b, required %h valid 1", byte_dat, byte_vld, pb);
        end
      end
      if (byte_vld && byte_rdy) begin
        got_q.push_back(byte_dat);
        got_t.push_back(cyc);
      end
      if (y_ack) ack_cnt++;
      pv = byte_vld;
      pr = byte_rdy;
      pb = byte_dat;
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, required finish before 400us");
    $fatal(1);
  end

  task automatic push_frame(input logic [31:0] d);
    exp_q.push_back(SYNC);
    for (int k = 3; k >= 0; k--) exp_q.push_back(d[8*k +: 8]);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Offer one sample; valid is dropped only once acked.
  task automatic send(input logic [31:0] d, input int budget, output bit ok);
    y_data = d;
    y_vld  = 1'b1;
    ok     = 1'b0;
    for (int i = 0; i < budget; i++) begin
      step();
      if (y_ack === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
    if (ok) y_vld = 1'b0;
  endtask

  task automatic wait_bytes(input int n, input int budget);
    for (int i = 0; i < budget; i++) begin
      if (got_q.size() >= n) break;
      step();
    end
  endtask

  task automatic clear_logs();
    got_q.delete();
    got_t.delete();
    exp_q.delete();
    ack_cnt = 0;
  endtask

  task automatic test_reset();
    rstn = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_checks += 5;
    if (y_ack !== 1'b0)    begin n_fail++; $display("FAIL reset_ack: got %b, required 0", y_ack); end
    if (byte_vld !== 1'b0) begin n_fail++; $display("FAIL reset_bvld: got %b, required 0", byte_vld); end
    if (byte_dat !== 8'h0) begin n_fail++; $display("FAIL reset_byte: got %h, required 00", byte_dat); end
    if (fifo_cnt !== 3'd0) begin n_fail++; $display("FAIL reset_cnt: got %0d, required 0", fifo_cnt); end
    if (ovf !== 1'b0)      begin n_fail++; $display("FAIL reset_ovf: got %b, required 0", ovf); end
    step();
    rstn = 1'b1;
    step();
  endtask

  task automatic test_single();
    bit ok;
    clear_logs();
    byte_rdy = 1'b1;
    push_frame(32'h3F800000);
    send(32'h3F800000, 10, ok);
    n_checks++;
    if (!ok) begin n_fail++; $display("FAIL single_ack: got no ack, required ack within 10 cycles"); end
    wait_bytes(5, 20);
    repeat (3) step();
    @(negedge clk);
    n_checks++;
    if (got_q.size() != exp_q.size()) begin n_fail++; $display("FAIL single_len: got %0d bytes, required %0d", got_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      n_checks++;
      if (got_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL single_byte%0d: got %h, required %h", i, got_q[i], exp_q[i]); end
      if (i > 0) begin
        n_checks++;
        if (got_t[i] !== got_t[i-1] + 1) begin n_fail++; $display("FAIL single_gap%0d: got cycle %0d, required %0d", i, got_t[i], got_t[i-1] + 1); end
      end
    end
    n_checks += 3;
    if (ack_cnt !== 1)     begin n_fail++; $display("FAIL single_acks: got %0d, required 1", ack_cnt); end
    if (fifo_cnt !== 3'd0) begin n_fail++; $display("FAIL single_cnt: got %0d, required 0", fifo_cnt); end
    if (byte_vld !== 1'b0) begin n_fail++; $display("FAIL single_idle: got valid %b, required 0", byte_vld); end
  endtask

  task automatic test_stall();
    bit ok;
    bit found;
    clear_logs();
    byte_rdy = 1'b1;
    push_frame(32'hBF636BE3);
    send(32'hBF636BE3, 10, ok);
    found = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (byte_vld === 1'b1 && byte_dat === 8'h63) begin
        found = 1'b1;
        break;
      end
      step();
    end
    byte_rdy = 1'b0;
    n_checks++;
    if (!found) begin n_fail++; $display("FAIL stall_find: byte 63 not presented, required within 20 cycles"); end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_checks++;
      if (byte_dat !== 8'h63 || byte_vld !== 1'b1) begin
        n_fail++;
        $display("FAIL stall_hold%0d: got %h valid %b, required 63 valid 1", i, byte_dat, byte_vld);
      end
    end
    step();
    byte_rdy = 1'b1;
    wait_bytes(5, 20);
    repeat (2) step();
    n_checks++;
    if (got_q.size() != exp_q.size()) begin n_fail++; $display("FAIL stall_len: got %0d bytes, required %0d", got_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      n_checks++;
      if (got_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL stall_byte%0d: got %h, required %h", i, got_q[i], exp_q[i]); end
    end
  endtask

  task automatic test_back_to_back();
    bit ok1;
    bit ok2;
    clear_logs();
    byte_rdy = 1'b0;
    push_frame(32'h11223344);
    push_frame(32'h55667788);
    send(32'h11223344, 10, ok1);
    send(32'h55667788, 10, ok2);
    n_checks++;
    if (!(ok1 && ok2)) begin n_fail++; $display("FAIL b2b_ack: got acks %b%b, required 11", ok1, ok2); end
    step();
    byte_rdy = 1'b1;
    wait_bytes(10, 30);
    repeat (3) step();
    n_checks++;
    if (got_q.size() != exp_q.size()) begin n_fail++; $display("FAIL b2b_len: got %0d bytes, required %0d", got_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      n_checks++;
      if (got_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL b2b_byte%0d: got %h, required %h", i, got_q[i], exp_q[i]); end
      if (i > 0) begin
        n_checks++;
        if (got_t[i] !== got_t[i-1] + 1) begin n_fail++; $display("FAIL b2b_gap%0d: got cycle %0d, required %0d", i, got_t[i], got_t[i-1] + 1); end
      end
    end
    n_checks++;
    if (fifo_cnt !== 3'd0) begin n_fail++; $display("FAIL b2b_cnt: got %0d, required 0", fifo_cnt); end
  endtask

  // Serializer holds sample 1; FIFO then absorbs four more, so the sixth meets a full FIFO.
  task automatic test_full();
    logic [31:0] d [6];
    bit ok;
    bit got_late;
    int n_acked;
    int exp_acked;
    int frames;
    clear_logs();
    byte_rdy = 1'b0;
    n_acked  = 0;
    ok       = 1'b0;
    for (int i = 0; i < 6; i++) d[i] = $urandom;
    for (int i = 0; i < 6; i++) begin
      send(d[i], 8, ok);
      if (ok) n_acked++;
    end
    exp_acked = DROP_MODE ? 6 : 5;
    frames    = DROP_MODE ? 5 : 6;
    for (int i = 0; i < frames; i++) push_frame(d[i]);
    @(negedge clk);
    n_checks += 3;
    if (n_acked !== exp_acked)        begin n_fail++; $display("FAIL full_acks: got %0d, required %0d", n_acked, exp_acked); end
    if (fifo_cnt !== 3'd4)            begin n_fail++; $display("FAIL full_cnt: got %0d, required 4", fifo_cnt); end
    if (ovf !== DROP_MODE)            begin n_fail++; $display("FAIL full_ovf: got %b, required %b", ovf, DROP_MODE); end
    step();
    byte_rdy = 1'b1;
    if (!ok) begin
      got_late = 1'b0;
      for (int i = 0; i < 20; i++) begin
        step();
        if (y_ack === 1'b1) begin
          got_late = 1'b1;
          break;
        end
      end
      y_vld = 1'b0;
      n_checks += 2;
      if (!got_late) begin n_fail++; $display("FAIL full_late_ack: got no ack, required ack after first pop"); end
      if (got_q.size() < 5 || got_q.size() > 6) begin
        n_fail++;
        $display("FAIL full_ack_time: got %0d bytes sent at ack, required 5..6", got_q.size());
      end
    end
    wait_bytes(exp_q.size(), 80);
    repeat (3) step();
    n_checks++;
    if (got_q.size() != exp_q.size()) begin n_fail++; $display("FAIL full_len: got %0d bytes, required %0d", got_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      n_checks++;
      if (got_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL full_byte%0d: got %h, required %h", i, got_q[i], exp_q[i]); end
    end
    n_checks += 2;
    if (fifo_cnt !== 3'd0) begin n_fail++; $display("FAIL full_drain: got %0d, required 0", fifo_cnt); end
    if (ovf !== DROP_MODE) begin n_fail++; $display("FAIL full_ovf_sticky: got %b, required %b", ovf, DROP_MODE); end
    clr_ovf = 1'b1;
    step();
    clr_ovf = 1'b0;
    @(negedge clk);
    n_checks++;
    if (ovf !== 1'b0) begin n_fail++; $display("FAIL full_clr: got %b, required 0", ovf); end
    step();
  endtask

  task automatic test_reset_mid();
    bit ok;
    clear_logs();
    byte_rdy = 1'b1;
    send(32'h3F800000, 10, ok);
    send(32'h12345678, 10, ok);
    wait_bytes(2, 20);
    step();
    rstn = 1'b0;
    #1;
    n_checks += 4;
    if (byte_vld !== 1'b0) begin n_fail++; $display("FAIL rmid_bvld: got %b, required 0", byte_vld); end
    if (byte_dat !== 8'h0) begin n_fail++; $display("FAIL rmid_byte: got %h, required 00", byte_dat); end
    if (fifo_cnt !== 3'd0) begin n_fail++; $display("FAIL rmid_cnt: got %0d, required 0", fifo_cnt); end
    if (y_ack !== 1'b0)    begin n_fail++; $display("FAIL rmid_ack: got %b, required 0", y_ack); end
    repeat (2) step();
    rstn = 1'b1;
    repeat (3) step();
    @(negedge clk);
    n_checks += 2;
    if (byte_vld !== 1'b0) begin n_fail++; $display("FAIL rmid_discard: got valid %b, required 0", byte_vld); end
    if (fifo_cnt !== 3'd0) begin n_fail++; $display("FAIL rmid_cnt2: got %0d, required 0", fifo_cnt); end
    step();
    clear_logs();
    push_frame(32'h40000000);
    send(32'h40000000, 10, ok);
    wait_bytes(5, 20);
    repeat (2) step();
    n_checks++;
    if (got_q.size() != exp_q.size()) begin n_fail++; $display("FAIL rmid_len: got %0d bytes, required %0d", got_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      n_checks++;
      if (got_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL rmid_byte%0d: got %h, required %h", i, got_q[i], exp_q[i]); end
    end
  endtask

  // Random producer gaps and random sink readiness; producer only offers when a slot is free.
  task automatic test_random();
    clear_logs();
    prod_done = 1'b0;
    fork
      begin
        bit ok;
        for (int i = 0; i < 24; i++) begin
          repeat ($urandom_range(0, 3)) step();
          for (int j = 0; j < 60; j++) begin
            if (fifo_cnt < 3'(DEPTH)) break;
            step();
          end
          rd = $urandom;
          send(rd, 60, ok);
          n_checks++;
          if (!ok) begin
            n_fail++;
            $display("FAIL rand_ack%0d: got no ack, required ack within 60 cycles", i);
            y_vld = 1'b0;
          end else begin
            push_frame(rd);
          end
        end
        prod_done = 1'b1;
      end
      begin
        for (int c = 0; c < 4000; c++) begin
          if (prod_done && got_q.size() >= exp_q.size()) break;
          byte_rdy = ($urandom_range(0, 3) != 0);
          step();
        end
        byte_rdy = 1'b1;
      end
    join
    repeat (3) step();
    n_checks++;
    if (got_q.size() != exp_q.size()) begin n_fail++; $display("FAIL rand_len: got %0d bytes, required %0d", got_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      n_checks++;
      if (got_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL rand_byte%0d: got %h, required %h", i, got_q[i], exp_q[i]); end
    end
    n_checks += 3;
    if (ovf !== 1'b0)      begin n_fail++; $display("FAIL rand_ovf: got %b, required 0", ovf); end
    if (fifo_cnt !== 3'd0) begin n_fail++; $display("FAIL rand_cnt: got %0d, required 0", fifo_cnt); end
    if (byte_vld !== 1'b0) begin n_fail++; $display("FAIL rand_idle: got valid %b, required 0", byte_vld); end
  endtask

  initial begin
    clk       = 1'b0;
    rstn      = 1'b0;
    y_data    = '0;
    y_vld     = 1'b0;
    byte_rdy  = 1'b0;
    clr_ovf   = 1'b0;
    n_checks  = 0;
    n_fail    = 0;
    cyc       = 0;
    ack_cnt   = 0;
    pv        = 1'b0;
    pr        = 1'b0;
    pb        = '0;
    prod_done = 1'b0;
    rd        = '0;
    test_reset();
    test_single();
    test_stall();
    test_back_to_back();
    test_full();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
